alu_writeback: RTL and testbench

//   Writeback stage directly downstream of the CR16 ALU. Accepts ALU result, status and

---
 rtl/cr16_pkg.sv | 48 ++++
 rtl/cr16_cond_eval.sv | 41 ++++
 rtl/alu_writeback.sv | 128 ++++++++++++
 tb/tb_alu_writeback.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cr16_pkg.sv
// ============================================================================
// cr16_pkg
// Shared CR16 writeback definitions: PSR bit indices, condition codes,
// skid-queue state encoding and the masked PSR merge helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cr16_pkg;

    localparam int PSR_C = 0;
    localparam int PSR_L = 1;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_HI = 4'd4;
    localparam logic [3:0] COND_LS = 4'd5;
    localparam logic [3:0] COND_GT = 4'd6;
    localparam logic [3:0] COND_LE = 4'd7;
    localparam logic [3:0] COND_FS = 4'd8;
    localparam logic [3:0] COND_FC = 4'd9;
    localparam logic [3:0] COND_LO = 4'd10;
    localparam logic [3:0] COND_HS = 4'd11;
    localparam logic [3:0] COND_LT = 4'd12;
    localparam logic [3:0] COND_GE = 4'd13;
    localparam logic [3:0] COND_UC = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam logic [1:0] Q_EMPTY = 2'd0;
    localparam logic [1:0] Q_ONE   = 2'd1;
    localparam logic [1:0] Q_TWO   = 2'd2;

    function automatic logic [4:0] psr_merge(
        input logic [4:0] psr,
        input logic [4:0] status,
        input logic [4:0] mask
    );
        return (psr & ~mask) | (status & mask);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cr16_cond_eval.sv
// ============================================================================
// cr16_cond_eval
// Combinational CR16 branch-condition evaluation of a PSR value.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cr16_cond_eval
    import cr16_pkg::*;
(
    input  logic [4:0] psr,
    input  logic [3:0] cond,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_EQ: cond_true =  psr[PSR_Z];
            COND_NE: cond_true = !psr[PSR_Z];
            COND_CS: cond_true =  psr[PSR_C];
            COND_CC: cond_true = !psr[PSR_C];
            COND_HI: cond_true =  psr[PSR_L];
            COND_LS: cond_true = !psr[PSR_L];
            COND_GT: cond_true =  psr[PSR_N];
            COND_LE: cond_true = !psr[PSR_N];
            COND_FS: cond_true =  psr[PSR_F];
            COND_FC: cond_true = !psr[PSR_F];
            COND_LO: cond_true = !psr[PSR_L] && !psr[PSR_Z];
            COND_HS: cond_true =  psr[PSR_L] ||  psr[PSR_Z];
            COND_LT: cond_true = !psr[PSR_N] && !psr[PSR_Z];
            COND_GE: cond_true =  psr[PSR_N] ||  psr[PSR_Z];
            COND_UC: cond_true = 1'b1;
            COND_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_writeback.sv
// ============================================================================
// alu_writeback
// CR16 writeback stage: 2-entry skid queue to the register file, PSR, and
// branch-condition evaluation. Option macro: CR16_WB_FLAG_BYPASS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_writeback
    import cr16_pkg::*;
#(
    parameter int P_WIDTH          = 16,
    parameter int P_REG_ADDR_WIDTH = 4
) (
    input  logic                        I_CLK,
    input  logic                        I_RESET,
    input  logic                        I_VALID,
    output logic                        O_READY,
    input  logic [P_WIDTH-1:0]          I_RESULT,
    input  logic [4:0]                  I_STATUS,
    input  logic [4:0]                  I_FLAG_MASK,
    input  logic                        I_WB_EN,
    input  logic [P_REG_ADDR_WIDTH-1:0] I_DEST,
    output logic                        O_WB_VALID,
    input  logic                        I_WB_READY,
    output logic [P_WIDTH-1:0]          O_WB_DATA,
    output logic [P_REG_ADDR_WIDTH-1:0] O_WB_ADDR,
    output logic [4:0]                  O_PSR,
    input  logic [3:0]                  I_COND,
    output logic                        O_COND_TRUE
);

    logic [1:0]                  r_state;
    logic [1:0]                  w_state_nxt;
    logic                        r_ready;
    logic [4:0]                  r_psr;
    logic [4:0]                  w_psr_nxt;
    logic [4:0]                  w_psr_eval;
    logic [P_WIDTH-1:0]          r_data0;
    logic [P_WIDTH-1:0]          r_data1;
    logic [P_REG_ADDR_WIDTH-1:0] r_addr0;
    logic [P_REG_ADDR_WIDTH-1:0] r_addr1;
    logic                        w_accept;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_wb_valid;

    assign w_wb_valid = (r_state != Q_EMPTY);
    assign w_accept   = I_VALID && r_ready;
    assign w_push     = w_accept && I_WB_EN;
    assign w_pop      = w_wb_valid && I_WB_READY;
    assign w_psr_nxt  = w_accept ? psr_merge(r_psr, I_STATUS, I_FLAG_MASK) : r_psr;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            Q_EMPTY: if (w_push) w_state_nxt = Q_ONE;
            Q_ONE: begin
                if (w_push && !w_pop)      w_state_nxt = Q_TWO;
                else if (!w_push && w_pop) w_state_nxt = Q_EMPTY;
            end
            Q_TWO:   if (w_pop) w_state_nxt = Q_ONE;
            default: w_state_nxt = Q_EMPTY;
        endcase
    end

    // Entry 0 is always the head; entry 1 only holds the second write in TWO.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_state <= Q_EMPTY;
            r_ready <= 1'b1;
            r_psr   <= 5'd0;
            r_data0 <= '0;
            r_data1 <= '0;
            r_addr0 <= '0;
            r_addr1 <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != Q_TWO);
            r_psr   <= w_psr_nxt;
            case (r_state)
                Q_EMPTY: begin
                    if (w_push) begin
                        r_data0 <= I_RESULT;
                        r_addr0 <= I_DEST;
                    end
                end
                Q_ONE: begin
                    if (w_push && w_pop) begin
                        r_data0 <= I_RESULT;
                        r_addr0 <= I_DEST;
                    end else if (w_push) begin
                        r_data1 <= I_RESULT;
                        r_addr1 <= I_DEST;
                    end
                end
                Q_TWO: begin
                    if (w_pop) begin
                        r_data0 <= r_data1;
                        r_addr0 <= r_addr1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CR16_WB_FLAG_BYPASS_EN
    assign w_psr_eval = w_psr_nxt;
`else
    assign w_psr_eval = r_psr;
`endif

    cr16_cond_eval u_cond_eval (
        .psr       (w_psr_eval),
        .cond      (I_COND),
        .cond_true (O_COND_TRUE)
    );

    assign O_READY    = r_ready;
    assign O_WB_VALID = w_wb_valid;
    assign O_WB_DATA  = r_data0;
    assign O_WB_ADDR  = r_addr0;
    assign O_PSR      = r_psr;

endmodule

`default_nettype wire

// File: tb/tb_alu_writeback.sv
// ============================================================================
// tb_alu_writeback
// Directed bench for alu_writeback with a queue/PSR reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        ready;
    logic [15:0] result = '0;
    logic [4:0]  status = '0;
    logic [4:0]  mask = '0;
    logic        wb_en = 1'b0;
    logic [3:0]  dest = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [15:0] wb_data;
    logic [3:0]  wb_addr;
    logic [4:0]  psr;
    logic [3:0]  cond = '0;
    logic        cond_true;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    alu_writeback #(.P_WIDTH(16), .P_REG_ADDR_WIDTH(4)) dut (
        .I_CLK       (clk),
        .I_RESET     (rst),
        .I_VALID     (valid),
        .O_READY     (ready),
        .I_RESULT    (result),
        .I_STATUS    (status),
        .I_FLAG_MASK (mask),
        .I_WB_EN     (wb_en),
        .I_DEST      (dest),
        .O_WB_VALID  (wb_valid),
        .I_WB_READY  (wb_ready),
        .O_WB_DATA   (wb_data),
        .O_WB_ADDR   (wb_addr),
        .O_PSR       (psr),
        .I_COND      (cond),
        .O_COND_TRUE (cond_true)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending writes and a PSR value.
    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  a;
    } wb_t;

    wb_t        m_q[$];
    logic [4:0] m_psr = 5'd0;
    bit         m_ready = 1'b1;

    function automatic logic cond_holds(input logic [4:0] p, input logic [3:0] c);
        logic n, z, f, l, cy;
        logic [15:0] table_bits;
        {n, z, f, l, cy} = p;
        table_bits = {1'b0, 1'b1, n | z, ~n & ~z, l | z, ~l & ~z, ~f, f,
                      ~n, n, ~l, l, ~cy, cy, ~z, z};
        return table_bits[c];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_psr   = 5'd0;
            m_ready = 1'b1;
        end else begin
            bit acc;
            acc = valid && m_ready;
            if (m_q.size() > 0 && wb_ready) void'(m_q.pop_front());
            if (acc && wb_en) m_q.push_back('{d: result, a: dest});
            if (acc) m_psr = (m_psr & ~mask) | (status & mask);
            m_ready = (m_q.size() < 2);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            logic [4:0] p_eval;
            p_eval = m_psr;
`ifdef CR16_WB_FLAG_BYPASS_EN
            if (valid && m_ready) p_eval = (m_psr & ~mask) | (status & mask);
`endif
            check("model_wb_valid", {31'd0, wb_valid}, {31'd0, m_q.size() > 0});
            if (m_q.size() > 0) begin
                check("model_wb_data", {16'd0, wb_data}, {16'd0, m_q[0].d});
                check("model_wb_addr", {28'd0, wb_addr}, {28'd0, m_q[0].a});
            end
            check("model_ready", {31'd0, ready}, {31'd0, m_ready});
            check("model_psr", {27'd0, psr}, {27'd0, m_psr});
            check("model_cond", {31'd0, cond_true}, {31'd0, cond_holds(p_eval, cond)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [15:0] r, input logic [3:0] d, input logic we,
                      input logic [4:0] st, input logic [4:0] mk);
        valid  = 1'b1;
        result = r;
        dest   = d;
        wb_en  = we;
        status = st;
        mask   = mk;
        tick();
        valid  = 1'b0;
    endtask

    localparam logic [3:0]  T5_CODES [8] = '{4'd0, 4'd1, 4'd11, 4'd10, 4'd13, 4'd12, 4'd14, 4'd15};
    localparam logic [7:0]  T5_EXP = 8'b0101_0101;

    initial begin
        // Reset release and reset-state pins
        tick();
        tick();
        rst = 1'b0;
        started = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_psr", {27'd0, psr}, 32'd0);
        tick();

        // Reset mid-queue in state TWO
        wb_ready = 1'b0;
        op(16'h0101, 4'd5, 1'b1, 5'h1f, 5'h1f);
        op(16'h0202, 4'd6, 1'b1, 5'h00, 5'h00);
        @(negedge clk);
        check("t1_full_ready", {31'd0, ready}, 32'd0);
        check("t1_psr_set", {27'd0, psr}, 32'h1f);
        tick();
        rst = 1'b1;
        #1;
        check("t1_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("t1_rst_psr", {27'd0, psr}, 32'd0);
        tick();
        rst = 1'b0;
        wb_ready = 1'b1;
        @(negedge clk);
        check("t1_rst_ready", {31'd0, ready}, 32'd1);
        check("t1_rst_data", {16'd0, wb_data}, 32'd0);
        tick();

        // Single write
        op(16'h1234, 4'd3, 1'b1, 5'h00, 5'h00);
        @(negedge clk);
        check("t2_valid", {31'd0, wb_valid}, 32'd1);
        check("t2_data", {16'd0, wb_data}, 32'h1234);
        check("t2_addr", {28'd0, wb_addr}, 32'd3);
        tick();
        @(negedge clk);
        check("t2_gone", {31'd0, wb_valid}, 32'd0);
        tick();

        // Backpressure and FIFO order
        wb_ready = 1'b0;
        op(16'hAAAA, 4'd1, 1'b1, 5'h00, 5'h00);
        op(16'h5555, 4'd2, 1'b1, 5'h00, 5'h00);
        @(negedge clk);
        check("t3_not_ready", {31'd0, ready}, 32'd0);
        tick();
        op(16'h7777, 4'd7, 1'b1, 5'h00, 5'h00);
        @(negedge clk);
        check("t3_head_data", {16'd0, wb_data}, 32'hAAAA);
        check("t3_head_addr", {28'd0, wb_addr}, 32'd1);
        tick();
        wb_ready = 1'b1;
        tick();
        @(negedge clk);
        check("t3_second_data", {16'd0, wb_data}, 32'h5555);
        check("t3_second_addr", {28'd0, wb_addr}, 32'd2);
        check("t3_ready_back", {31'd0, ready}, 32'd1);
        tick();
        @(negedge clk);
        check("t3_drained", {31'd0, wb_valid}, 32'd0);
        tick();

        // PSR masking, no-write ops
        op(16'h0000, 4'd0, 1'b0, 5'b00000, 5'b11111);
        op(16'h0000, 4'd0, 1'b0, 5'b11111, 5'b01001);
        @(negedge clk);
        check("t4_psr_masked", {27'd0, psr}, 32'b01001);
        check("t4_no_push", {31'd0, wb_valid}, 32'd0);
        tick();
        op(16'h0000, 4'd0, 1'b0, 5'b00000, 5'b00000);
        @(negedge clk);
        check("t4_psr_hold", {27'd0, psr}, 32'b01001);
        tick();

        // Condition codes with Z=1, L=0, N=0
        for (int i = 0; i < 8; i++) begin
            cond = T5_CODES[i];
            @(negedge clk);
            check($sformatf("t5_cond_%0d", T5_CODES[i]), {31'd0, cond_true}, {31'd0, T5_EXP[i]});
            tick();
        end

        // Same-cycle flag forwarding
        op(16'h0000, 4'd0, 1'b0, 5'b00000, 5'b11111);
        cond   = 4'd0;
        valid  = 1'b1;
        wb_en  = 1'b0;
        status = 5'b01000;
        mask   = 5'b01000;
        #1;
`ifdef CR16_WB_FLAG_BYPASS_EN
        check("t6_bypass_same", {31'd0, cond_true}, 32'd1);
`else
        check("t6_nobypass_same", {31'd0, cond_true}, 32'd0);
`endif
        tick();
        valid = 1'b0;
        #1;
        check("t6_next_cycle", {31'd0, cond_true}, 32'd1);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
